// File: rtl/flt_pkg.sv
// Shared constants and state type for the half-precision float to integer converter.
// Field widths, exponent bias and the exponent thresholds that pick the shift direction live here.
package flt_pkg;

  localparam int FLT_BIAS = 15;
  localparam int EXP_W    = 5;
  localparam int MANT_W   = 10;
  localparam int FLT_W    = 1 + EXP_W + MANT_W;
  localparam int MAG_W    = FLT_W - 1;

  // Exponents below EXP_RSH_MIN round to zero, EXP_LSH_BASE is the point where the
  // mantissa LSB has weight 1, and EXP_OVF_MIN and above saturate.
  localparam int EXP_RSH_MIN  = 14;
  localparam int EXP_LSH_BASE = 25;
  localparam int EXP_OVF_MIN  = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/flt2int_unit.sv
// Multi-cycle half-float to sign-magnitude integer converter: one shift per cycle, then
// round-to-nearest-even. Handshake: start is sampled only in IDLE; done pulses for one cycle with int_out/ovf valid.
module flt2int_unit
  import flt_pkg::*;
#(
  parameter int BIAS      = 15,
  parameter int MAX_SHIFT = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [FLT_W-1:0] flt_in,
  output logic [FLT_W-1:0] int_out,
  output logic             done,
  output logic             busy,
  output logic             ovf,
  output state_t           state_dbg
);

  localparam int CNT_W   = $clog2(MAX_SHIFT + 1);
  localparam int EXP_LO  = EXP_RSH_MIN + BIAS - FLT_BIAS;
  localparam int EXP_LSH = EXP_LSH_BASE + BIAS - FLT_BIAS;
  localparam int EXP_OVF = EXP_OVF_MIN + BIAS - FLT_BIAS;

  state_t             state;
  logic [MAG_W-1:0]   mag;
  logic [CNT_W-1:0]   cnt;
  logic               rnd;
  logic               sticky;
  logic               sign_q;
  logic               left_q;
  logic               ovf_q;

  logic [EXP_W-1:0]   exp_f;
  logic [MANT_W-1:0]  mant_f;
  logic [MAG_W-1:0]   mag_init;
  logic [CNT_W-1:0]   cnt_init;
  logic               left_init;
  logic               ovf_init;
  logic               rnd_inc;
  logic [MAG_W-1:0]   mag_rnd;

  assign exp_f     = flt_in[MAG_W-1 -: EXP_W];
  assign mant_f    = flt_in[MANT_W-1:0];
  assign state_dbg = state;

  // Decode the captured exponent into an initial magnitude, shift count and direction.
  always_comb begin
    mag_init  = MAG_W'({1'b1, mant_f});
    cnt_init  = '0;
    left_init = 1'b0;
    ovf_init  = 1'b0;
    if (int'(exp_f) >= EXP_OVF) begin
      mag_init = '1;
      ovf_init = 1'b1;
    end else if (int'(exp_f) >= EXP_LSH) begin
      left_init = 1'b1;
      cnt_init  = CNT_W'(int'(exp_f) - EXP_LSH);
    end else if (int'(exp_f) >= EXP_LO) begin
      cnt_init = CNT_W'(EXP_LSH - int'(exp_f));
    end else begin
      mag_init = '0;
    end
  end

  // Round half to even: bump only when the guard bit is set and the discarded tail or LSB is odd.
  assign rnd_inc = rnd & (sticky | mag[0]);
  assign mag_rnd = mag + MAG_W'(rnd_inc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      mag     <= '0;
      cnt     <= '0;
      rnd     <= 1'b0;
      sticky  <= 1'b0;
      sign_q  <= 1'b0;
      left_q  <= 1'b0;
      ovf_q   <= 1'b0;
      int_out <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign_q <= flt_in[FLT_W-1];
            mag    <= mag_init;
            cnt    <= cnt_init;
            left_q <= left_init;
            ovf_q  <= ovf_init;
            rnd    <= 1'b0;
            sticky <= 1'b0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            if (left_q) begin
              mag <= mag << 1;
            end else begin
              sticky <= sticky | rnd;
              rnd    <= mag[0];
              mag    <= mag >> 1;
            end
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          mag     <= mag_rnd;
          int_out <= {sign_q, mag_rnd};
          ovf     <= ovf_q;
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flt2int_unit.sv
// Directed and randomized checks of flt2int_unit against an arithmetic rounding model.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_flt2int_unit;
  import flt_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] flt_in;
  logic [15:0] int_out;
  logic        done;
  logic        busy;
  logic        ovf;
  state_t      state_dbg;

  int checks;
  int errors;

  flt2int_unit #(.BIAS(15), .MAX_SHIFT(11)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .flt_in   (flt_in),
    .int_out  (int_out),
    .done     (done),
    .busy     (busy),
    .ovf      (ovf),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: value = (1.mant) * 2^(exp-25), rounded half to even on the exact remainder.
  function automatic void ref_model(input logic [15:0] f, output logic [15:0] r,
                                    output logic o, output int lat);
    int e, m, q, s, rem, half;
    e = int'(f[14:10]);
    m = 1024 + int'(f[9:0]);
    o = 1'b0;
    if (e >= 30) begin
      q = 32'h7FFF; o = 1'b1; lat = 2;
    end else if (e >= 25) begin
      q = m * (1 << (e - 25)); lat = e - 25 + 2;
    end else if (e >= 14) begin
      s = 25 - e;
      q = m / (1 << s);
      rem = m - q * (1 << s);
      half = 1 << (s - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      lat = s + 2;
    end else begin
      q = 0; lat = 2;
    end
    r = {f[15], q[14:0]};
  endfunction

  task automatic conv(input logic [15:0] f, input logic [15:0] exp_out, input logic exp_ovf,
                      input int exp_lat, input string tag);
    int  lat;
    bit  seen;
    @(negedge clk);
    flt_in = f;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 30 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_int_out"}, 32'(int_out), 32'(exp_out));
      chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_held"}, 32'(int_out), 32'(exp_out));
      chk({tag, "_idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] f, r;
    logic        o;
    int          lat, pulses, rand_err0;

    checks = 0;
    errors = 0;
    reset  = 1'b0;
    start  = 1'b0;
    flt_in = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_int_out", 32'(int_out), 32'h0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    conv(16'h3C00, 16'h0001, 1'b0, 12, "one");
    conv(16'h4100, 16'h0002, 1'b0, 11, "two_half");
    conv(16'h4300, 16'h0004, 1'b0, 11, "three_half");
    conv(16'h3800, 16'h0000, 1'b0, 13, "half");
    conv(16'h3A00, 16'h0001, 1'b0, 13, "three_quarter");
    conv(16'h77FF, 16'h7FF0, 1'b0, 6, "max_finite");
    conv(16'hFC00, 16'hFFFF, 1'b1, 2, "neg_inf");
    conv(16'h8000, 16'h8000, 1'b0, 2, "neg_zero");
    conv(16'h7C01, 16'h7FFF, 1'b1, 2, "nan");
    conv(16'h0001, 16'h0000, 1'b0, 2, "denormal");
    conv(16'hB3FF, 16'h8000, 1'b0, 2, "small_neg");
    conv(16'h7800, 16'h7FFF, 1'b1, 2, "exp30");

    // A second start while busy must be dropped, leaving exactly one done pulse.
    @(negedge clk);
    flt_in = 16'h3C00;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    flt_in = 16'hFC00;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("busy_ignore_pulses", 32'(pulses), 32'd1);
    chk("busy_ignore_int_out", 32'(int_out), 32'h0001);
    chk("busy_ignore_ovf", 32'(ovf), 32'd0);
    chk("busy_ignore_idle", 32'(busy), 32'd0);

    // Reset in the middle of SHIFT aborts the conversion without a done pulse.
    @(negedge clk);
    flt_in = 16'hC100;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_int_out", 32'(int_out), 32'h0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    reset  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("midreset_no_done", 32'(pulses), 32'd0);
    conv(16'h3C00, 16'h0001, 1'b0, 12, "after_reset");

    // Start held high restarts on the IDLE cycle after DONE: one result every 4 cycles.
    @(negedge clk);
    flt_in = 16'h8000;
    start  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("held_start_pulses", 32'(pulses), 32'd4);
    chk("held_start_int_out", 32'(int_out), 32'h8000);

    // Randomized finite values with exponent 14..29.
    rand_err0 = errors;
    for (int t = 0; t < 250; t++) begin
      f[15]    = 1'($urandom_range(0, 1));
      f[14:10] = 5'($urandom_range(14, 29));
      f[9:0]   = 10'($urandom_range(0, 1023));
      ref_model(f, r, o, lat);
      conv(f, r, o, lat, $sformatf("rand%0d_%04h", t, f));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    $display("Random trials: 250, errors in random phase: %0d", errors - rand_err0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
